// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  localparam int unsigned WORD_BYTES      = 4;
  localparam logic [1:0]  ADDR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive arbitrations lost by the fetch requester.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  assign sat = (cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates fetch and load/store access to one shared word memory:
// grant -> one ACCESS cycle -> one RESP cycle, with fetch starvation override.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_BYTES  = 65536,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, stateNext;
  owner_t            ownerQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic              weQ;
  logic              arbitrating, fetchWins, starveSat, addrLegal, inAccess;
  logic [DATA_W-1:0] respData;

  assign arbitrating = (state != ACCESS);
  assign fetchWins   = if_req && (!d_req || starveSat);
  assign if_gnt      = arbitrating && fetchWins;
  assign d_gnt       = arbitrating && d_req && !fetchWins;
  assign inAccess    = (state == ACCESS);

  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) uStarve (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (arbitrating && if_req && d_gnt),
    .clr  (if_gnt),
    .sat  (starveSat)
  );

  assign addrLegal = ((addrQ[1:0] & ADDR_ALIGN_MASK) == 2'b00) &&
                     (addrQ <= ADDR_W'(MEM_BYTES - WORD_BYTES));

  // mem_write is decoded from the state register so an async reset kills it at once
  assign mem_write = inAccess && weQ && addrLegal;
  assign mem_adr   = inAccess ? addrQ  : '0;
  assign mem_wdata = inAccess ? wdataQ : '0;
  assign respData  = (addrLegal && !weQ) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (if_gnt || d_gnt) stateNext = ACCESS;
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = (if_gnt || d_gnt) ? ACCESS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrQ     <= '0;
      wdataQ    <= '0;
      weQ       <= 1'b0;
      ownerQ    <= OWN_IF;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      if (if_gnt) begin
        addrQ  <= if_addr;
        wdataQ <= '0;
        weQ    <= 1'b0;
        ownerQ <= OWN_IF;
      end else if (d_gnt) begin
        addrQ  <= d_addr;
        wdataQ <= d_wdata;
        weQ    <= d_we;
        ownerQ <= OWN_D;
      end
      if_rvalid <= inAccess && (ownerQ == OWN_IF);
      d_rvalid  <= inAccess && (ownerQ == OWN_D);
      if (inAccess && ownerQ == OWN_IF) begin
        if_rdata <= respData;
        if_err   <= !addrLegal;
      end
      if (inAccess && ownerQ == OWN_D) begin
        d_rdata <= respData;
        d_err   <= !addrLegal;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_imem_dmem_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_BYTES  = 65536;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid, if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_gnt, d_rvalid, d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  imem_dmem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_BYTES (MEM_BYTES),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_write(mem_write),
    .mem_adr  (mem_adr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT, and the model's own copy.
  logic [7:0] mem    [MEM_BYTES];
  logic [7:0] refMem [MEM_BYTES];
  logic [15:0] rdA;

  assign rdA = mem_adr[15:0];
  always_comb begin
    mem_rdata = '0;
    if (mem_adr <= 32'(MEM_BYTES - 4))
      mem_rdata = {mem[rdA], mem[rdA + 16'd1], mem[rdA + 16'd2], mem[rdA + 16'd3]};
  end

  always @(posedge clk) begin
    if (rst_n && mem_write && mem_adr <= 32'(MEM_BYTES - 4)) begin
      mem[rdA]         <= mem_wdata[31:24];
      mem[rdA + 16'd1] <= mem_wdata[23:16];
      mem[rdA + 16'd2] <= mem_wdata[15:8];
      mem[rdA + 16'd3] <= mem_wdata[7:0];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(MEM_BYTES - 4));
  endfunction

  function automatic logic [31:0] refWord(input logic [31:0] a);
    logic [15:0] i;
    i = a[15:0];
    return {refMem[i], refMem[i + 16'd1], refMem[i + 16'd2], refMem[i + 16'd3]};
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [15:0] i;
    i = a[15:0];
    return {mem[i], mem[i + 16'd1], mem[i + 16'd2], mem[i + 16'd3]};
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    logic [15:0] i;
    i = a[15:0];
    {mem[i], mem[i + 16'd1], mem[i + 16'd2], mem[i + 16'd3]} = w;
    {refMem[i], refMem[i + 16'd1], refMem[i + 16'd2], refMem[i + 16'd3]} = w;
  endtask

  // Reference model: a granted request occupies the next cycle as the memory
  // access, and its response appears the cycle after that.
  bit          mAcc, mWe, mOwnD, mResp, mRespD, mErr;
  logic [31:0] mAddr, mWdata, mRdata;
  int          mStarve;

  always @(negedge clk) begin
    bit arb, eIf, eD, lg;
    if (!rst_n) begin
      mAcc = 0; mResp = 0; mStarve = 0;
    end else begin
      arb = !mAcc;
      eIf = arb && if_req && (!d_req || mStarve >= int'(STARVE_MAX));
      eD  = arb && d_req && !eIf;
      lg  = legal(mAddr);
      chk("if_gnt", 32'(if_gnt), 32'(eIf));
      chk("d_gnt", 32'(d_gnt), 32'(eD));
      chk("mem_write", 32'(mem_write), 32'(mAcc && mWe && lg));
      chk("mem_adr", mem_adr, mAcc ? mAddr : 32'h0);
      chk("mem_wdata", mem_wdata, mAcc ? mWdata : 32'h0);
      chk("if_rvalid", 32'(if_rvalid), 32'(mResp && !mRespD));
      chk("d_rvalid", 32'(d_rvalid), 32'(mResp && mRespD));
      if (mResp && !mRespD) begin
        chk("if_rdata", if_rdata, mRdata);
        chk("if_err", 32'(if_err), 32'(mErr));
      end
      if (mResp && mRespD) begin
        chk("d_rdata", d_rdata, mRdata);
        chk("d_err", 32'(d_err), 32'(mErr));
      end
      mResp = mAcc;
      if (mAcc) begin
        mRespD = mOwnD;
        mErr   = !lg;
        mRdata = (lg && !mWe) ? refWord(mAddr) : 32'h0;
        if (lg && mWe)
          {refMem[mAddr[15:0]], refMem[mAddr[15:0] + 16'd1],
           refMem[mAddr[15:0] + 16'd2], refMem[mAddr[15:0] + 16'd3]} = mWdata;
      end
      if (eIf) mStarve = 0;
      else if (eD && if_req && mStarve < int'(STARVE_MAX)) mStarve++;
      mAcc = eIf || eD;
      if (eIf) begin
        mAddr = if_addr; mWe = 0; mWdata = 0; mOwnD = 0;
      end else if (eD) begin
        mAddr = d_addr; mWe = d_we; mWdata = d_wdata; mOwnD = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkZero(input string tag);
    chk({tag, " if_gnt"}, 32'(if_gnt), 0);
    chk({tag, " if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, " if_rdata"}, if_rdata, 0);
    chk({tag, " if_err"}, 32'(if_err), 0);
    chk({tag, " d_gnt"}, 32'(d_gnt), 0);
    chk({tag, " d_rvalid"}, 32'(d_rvalid), 0);
    chk({tag, " d_rdata"}, d_rdata, 0);
    chk({tag, " d_err"}, 32'(d_err), 0);
    chk({tag, " mem_write"}, 32'(mem_write), 0);
    chk({tag, " mem_adr"}, mem_adr, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom % 8)
      0, 1, 2, 3, 4: return ($urandom % 64) << 2;
      5:             return 32'hFFFC;
      6:             return (($urandom % 64) << 2) | (1 + $urandom % 3);
      default:       return 32'h10000 + (($urandom % 4) << 2);
    endcase
  endfunction

  initial begin
    int n;
    logic [9:0] ord;
    bit ifPend, dPend, ifGot, dGot;

    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      mem[i] = 8'($urandom);
      refMem[i] = mem[i];
    end
    poke(32'h0, 32'h00000013);
    poke(32'h4, 32'h00100093);
    poke(32'h10, 32'h11223344);
    poke(32'hFFFC, 32'hAAAAAAAA);

    // Power-on reset
    #1 rst_n = 1'b0;
    #12 chkZero("reset");
    tick();
    rst_n = 1'b1;
    #2 chkZero("release");
    tick();

    // Single fetch from 0x0
    tick(); if_req = 1; if_addr = 32'h0;
    #3 chk("fetch gnt", 32'(if_gnt), 1);
    tick(); if_req = 0;
    #3 chk("fetch mem_adr", mem_adr, 32'h0);
    chk("fetch rvalid early", 32'(if_rvalid), 0);
    tick();
    #3 chk("fetch rvalid", 32'(if_rvalid), 1);
    chk("fetch rdata", if_rdata, 32'h00000013);
    chk("fetch err", 32'(if_err), 0);

    // Store then load at 0x100; the load is granted during the store's response
    tick(); d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    #3 chk("store gnt", 32'(d_gnt), 1);
    tick(); d_req = 0;
    #3 chk("store mem_write", 32'(mem_write), 1);
    tick(); d_req = 1; d_we = 0;
    #3 chk("store rvalid", 32'(d_rvalid), 1);
    chk("store rdata", d_rdata, 32'h0);
    chk("load gnt", 32'(d_gnt), 1);
    tick(); d_req = 0;
    #3 chk("load mem_write", 32'(mem_write), 0);
    tick();
    #3 chk("load rvalid", 32'(d_rvalid), 1);
    chk("load rdata", d_rdata, 32'hDEADBEEF);
    tick();

    // Both requesters held continuously
    tick(); if_req = 1; if_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h8;
    n = 0; ord = '0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      if (c > 0) tick();
      #3 chk("both gnt", 32'(if_gnt & d_gnt), 0);
      if (if_gnt || d_gnt) begin
        ord = {ord[8:0], if_gnt};
        n++;
      end
    end
    chk("grant count", 32'(n), 10);
    chk("grant order", 32'(ord), 32'b0000100001);
    tick(); if_req = 0; d_req = 0;
    tick(); tick();

    // Misaligned load, then out-of-range store
    tick(); d_req = 1; d_we = 0; d_addr = 32'h102;
    #3 chk("misalign gnt", 32'(d_gnt), 1);
    tick(); d_req = 0;
    #3 chk("misalign mem_write", 32'(mem_write), 0);
    tick(); d_req = 1; d_we = 1; d_addr = 32'hFFFE; d_wdata = 32'h55555555;
    #3 chk("misalign err", 32'(d_err), 1);
    chk("misalign rdata", d_rdata, 32'h0);
    chk("range gnt", 32'(d_gnt), 1);
    tick(); d_req = 0; d_we = 0;
    #3 chk("range mem_write", 32'(mem_write), 0);
    tick();
    #3 chk("range rvalid", 32'(d_rvalid), 1);
    chk("range err", 32'(d_err), 1);
    chk("range rdata", d_rdata, 32'h0);
    chk("range mem", memWord(32'hFFFC), 32'hAAAAAAAA);
    tick();

    // Back-to-back fetches
    tick(); if_req = 1; if_addr = 32'h0;
    #3 chk("b2b gnt0", 32'(if_gnt), 1);
    tick(); if_req = 0;
    tick(); if_req = 1; if_addr = 32'h4;
    #3 chk("b2b rvalid0", 32'(if_rvalid), 1);
    chk("b2b rdata0", if_rdata, 32'h00000013);
    chk("b2b gnt1", 32'(if_gnt), 1);
    tick(); if_req = 0;
    tick();
    #3 chk("b2b rvalid1", 32'(if_rvalid), 1);
    chk("b2b rdata1", if_rdata, 32'h00100093);
    tick();

    // Reset during the access cycle of a store to 0x10
    tick(); d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h12345678;
    #3 chk("rst store gnt", 32'(d_gnt), 1);
    tick(); d_req = 0; d_we = 0;
    chk("rst mem_write before", 32'(mem_write), 1);
    #1 rst_n = 1'b0;
    #1 chk("rst mem_write async", 32'(mem_write), 0);
    tick(); tick();
    rst_n = 1'b1;
    #2 chkZero("midreset");
    chk("rst mem unchanged", memWord(32'h10), 32'h11223344);
    tick(); tick();
    chk("rst no rvalid", 32'(d_rvalid | if_rvalid), 0);

    // Random traffic
    ifPend = 0; dPend = 0; ifGot = 0; dGot = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (ifGot) ifPend = 0;
      if (dGot) dPend = 0;
      if (!ifPend && ($urandom % 2 == 0)) begin
        ifPend = 1; if_addr = randAddr();
      end else if (ifPend && ($urandom % 16 == 0)) begin
        ifPend = 0;
      end
      if (!dPend && ($urandom % 2 == 0)) begin
        dPend = 1; d_addr = randAddr(); d_we = 1'($urandom % 2); d_wdata = $urandom;
      end else if (dPend && ($urandom % 16 == 0)) begin
        dPend = 0;
      end
      if_req = ifPend;
      d_req = dPend;
      #3 ifGot = if_gnt; dGot = d_gnt;
    end
    tick(); if_req = 0; d_req = 0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
